tile_frame_scheduler: RTL

- Sequences the per-frame update of the piano-tiles playfield: on each game tick, runs the shift drawer (move tile rows down one lane), then the spawn drawer (draw a new tile in the top row).
- Owns the single VGA adapter write port and grants it to exactly one drawer at a time.
- Sits between the game-speed timebase, the shift/spawn drawing FSMs, and the vga_adapter (x, y, colour, write).

---
 rtl/tiles_pkg.sv | 29 ++
 rtl/tile_tick_gen.sv | 37 +++
 rtl/tile_frame_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tiles_pkg.sv
// Shared widths, phase encoding and grant encoding for the piano-tiles frame scheduler.
package tiles_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int C_W = 3;
  localparam int TICK_CYCLES_DEF = 2500000;
  localparam int WD_CYCLES_DEF = 65536;

  typedef logic [2:0] phase_t;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SHIFT_GO   = 3'd1;
  localparam logic [2:0] ST_SHIFT_WAIT = 3'd2;
  localparam logic [2:0] ST_SPAWN_GO   = 3'd3;
  localparam logic [2:0] ST_SPAWN_WAIT = 3'd4;
  localparam logic [2:0] ST_FINISH     = 3'd5;

  typedef enum logic [1:0] {GNT_NONE, GNT_SHIFT, GNT_SPAWN} gnt_t;

  // Which drawer owns the VGA write port in a given phase.
  function automatic gnt_t grant_of(input phase_t st);
    gnt_t g;
    g = GNT_NONE;
    if (st == ST_SHIFT_GO || st == ST_SHIFT_WAIT) g = GNT_SHIFT;
    if (st == ST_SPAWN_GO || st == ST_SPAWN_WAIT) g = GNT_SPAWN;
    return g;
  endfunction

endpackage

// File: rtl/tile_tick_gen.sv
// Game-speed timebase: tick every TICK_CYCLES enabled cycles, one-deep pending queue, sticky overrun.
module tile_tick_gen
  import tiles_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic take,
  output logic pending,
  output logic overrun
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          tick;

  assign tick = enable && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (enable) cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      // A tick coinciding with the FSM taking the queued one simply re-queues.
      if (tick) pending <= 1'b1;
      else if (take) pending <= 1'b0;
      if (tick && pending && !take) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/tile_frame_scheduler.sv
// Per-tick frame sequencer (shift then spawn) and owner of the single VGA write port.
// Optional WATCHDOG_EN macro adds a per-phase timeout that sets a sticky error.
module tile_frame_scheduler #(
  parameter int TICK_CYCLES = tiles_pkg::TICK_CYCLES_DEF,
  parameter int X_W = tiles_pkg::X_W,
  parameter int Y_W = tiles_pkg::Y_W,
`ifdef WATCHDOG_EN
  parameter int WD_CYCLES = tiles_pkg::WD_CYCLES_DEF,
`endif
  parameter int C_W = tiles_pkg::C_W
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           enable,
  output logic           shift_start,
  input  logic           shift_done,
  input  logic [X_W-1:0] shift_x,
  input  logic [Y_W-1:0] shift_y,
  input  logic [C_W-1:0] shift_color,
  input  logic           shift_plot,
  output logic           spawn_start,
  input  logic           spawn_done,
  input  logic [X_W-1:0] spawn_x,
  input  logic [Y_W-1:0] spawn_y,
  input  logic [C_W-1:0] spawn_color,
  input  logic           spawn_plot,
  output logic [X_W-1:0] VGA_X,
  output logic [Y_W-1:0] VGA_Y,
  output logic [C_W-1:0] VGA_COLOR,
  output logic           plot,
  output logic           frame_done,
  output logic           busy,
  output logic           overrun,
  output logic           error
);
  import tiles_pkg::*;

  phase_t state_reg, state_next;
  logic   pending;
  logic   take;
  logic   in_wait;
  logic   wd_expired;
  gnt_t   grant;

  assign take    = (state_reg == ST_IDLE) && pending && enable;
  assign in_wait = (state_reg == ST_SHIFT_WAIT) || (state_reg == ST_SPAWN_WAIT);
  assign grant   = grant_of(state_reg);

  tile_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (CLOCK_50),
    .rst     (reset),
    .enable  (enable),
    .take    (take),
    .pending (pending),
    .overrun (overrun)
  );

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES) + 1;
  logic [WD_W-1:0] wd_reg;
  logic            wd_done;

  assign wd_expired = in_wait && (wd_reg == WD_W'(WD_CYCLES - 1));
  assign wd_done    = (state_reg == ST_SHIFT_WAIT) ? shift_done : spawn_done;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wd_reg <= '0;
      error  <= 1'b0;
    end else begin
      if (state_reg == ST_SHIFT_GO || state_reg == ST_SPAWN_GO) wd_reg <= '0;
      else if (in_wait) wd_reg <= wd_reg + 1'b1;
      if (wd_expired && !wd_done) error <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

  // Done inputs are looked at only in their own WAIT state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (pending && enable) state_next = ST_SHIFT_GO;
      ST_SHIFT_GO:   state_next = ST_SHIFT_WAIT;
      ST_SHIFT_WAIT: if (shift_done || wd_expired) state_next = ST_SPAWN_GO;
      ST_SPAWN_GO:   state_next = ST_SPAWN_WAIT;
      ST_SPAWN_WAIT: if (spawn_done || wd_expired) state_next = ST_FINISH;
      ST_FINISH:     state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  assign shift_start = (state_reg == ST_SHIFT_GO);
  assign spawn_start = (state_reg == ST_SPAWN_GO);
  assign frame_done  = (state_reg == ST_FINISH);
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);

  // Coordinates hold when nobody owns the port; only plot is forced low.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      VGA_X     <= '0;
      VGA_Y     <= '0;
      VGA_COLOR <= '0;
      plot      <= 1'b0;
    end else begin
      case (grant)
        GNT_SHIFT: begin
          VGA_X     <= shift_x;
          VGA_Y     <= shift_y;
          VGA_COLOR <= shift_color;
          plot      <= shift_plot;
        end
        GNT_SPAWN: begin
          VGA_X     <= spawn_x;
          VGA_Y     <= spawn_y;
          VGA_COLOR <= spawn_color;
          plot      <= spawn_plot;
        end
        default: plot <= 1'b0;
      endcase
    end
  end

endmodule
